// File: rtl/div_arbiter_if.sv
// Bundle of requester-side and divider-side signals for div_arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface div_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             Req0;
    logic             Req1;
    logic [WIDTH-1:0] Dividend0;
    logic [WIDTH-1:0] Dividend1;
    logic [WIDTH-1:0] Divisor0;
    logic [WIDTH-1:0] Divisor1;
    logic             Grant0;
    logic             Grant1;
    logic             Valid0;
    logic             Valid1;
    logic [WIDTH-1:0] Quotient0;
    logic [WIDTH-1:0] Quotient1;
    logic             Error0;
    logic             Error1;
    logic             Busy;
    logic             Div_Start;
    logic [WIDTH-1:0] Div_Dividend;
    logic [WIDTH-1:0] Div_Divisor;
    logic [WIDTH-1:0] Div_Quotient;
    logic             Div_Done;

    modport master (
        output Req0, Req1, Dividend0, Dividend1, Divisor0, Divisor1,
        output Div_Quotient, Div_Done,
        input  Grant0, Grant1, Valid0, Valid1, Quotient0, Quotient1,
        input  Error0, Error1, Busy, Div_Start, Div_Dividend, Div_Divisor
    );

    modport slave (
        input  Req0, Req1, Dividend0, Dividend1, Divisor0, Divisor1,
        input  Div_Quotient, Div_Done,
        output Grant0, Grant1, Valid0, Valid1, Quotient0, Quotient1,
        output Error0, Error1, Busy, Div_Start, Div_Dividend, Div_Divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one external divider between two requesters,
// with divide-by-zero short-cut and a WAIT timeout that forces an error result.
module div_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input logic          Clock,
    input logic          Reset,
    div_arbiter_if.slave bus
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             served_q, served_d;
    logic             done_d_q, done_d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_err_q, res_err_d;
    logic             grant0_q, grant0_d, grant1_q, grant1_d;
    logic             valid0_q, valid0_d, valid1_q, valid1_d;
    logic [WIDTH-1:0] quot0_q, quot0_d, quot1_q, quot1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic             pick1;
    logic [WIDTH-1:0] sel_dvs;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        served_d  = served_q;
        done_d_d  = bus.Div_Done;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_err_d = res_err_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        valid0_d  = 1'b0;
        valid1_d  = 1'b0;
        quot0_d   = quot0_q;
        quot1_d   = quot1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        start_d   = 1'b0;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        // On a tie, requester 1 wins only if requester 1 was not the last one served.
        pick1     = bus.Req1 && (!bus.Req0 || !last_q);
        sel_dvs   = pick1 ? bus.Divisor1 : bus.Divisor0;

        case (state_q)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    last_d   = pick1;
                    served_d = pick1;
                    grant0_d = !pick1;
                    grant1_d = pick1;
                    dvd_d    = pick1 ? bus.Dividend1 : bus.Dividend0;
                    dvs_d    = sel_dvs;
                    if (sel_dvs != '0) begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end else begin
                        state_d   = RESP;
                        res_d     = '0;
                        res_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A completion edge takes priority over a timeout in the same cycle.
                if (bus.Div_Done && !done_d_q) begin
                    state_d   = RESP;
                    res_d     = bus.Div_Quotient;
                    res_err_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    res_d     = '0;
                    res_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (served_q) begin
                    valid1_d = 1'b1;
                    quot1_d  = res_q;
                    err1_d   = res_err_q;
                end else begin
                    valid0_d = 1'b1;
                    quot0_d  = res_q;
                    err0_d   = res_err_q;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            served_q  <= 1'b0;
            done_d_q  <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_err_q <= 1'b0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            quot0_q   <= '0;
            quot1_q   <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            served_q  <= served_d;
            done_d_q  <= done_d_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            res_err_q <= res_err_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            quot0_q   <= quot0_d;
            quot1_q   <= quot1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
        end
    end

    assign bus.Grant0       = grant0_q;
    assign bus.Grant1       = grant1_q;
    assign bus.Valid0       = valid0_q;
    assign bus.Valid1       = valid1_q;
    assign bus.Quotient0    = quot0_q;
    assign bus.Quotient1    = quot1_q;
    assign bus.Error0       = err0_q;
    assign bus.Error1       = err1_q;
    assign bus.Busy         = busy_q;
    assign bus.Div_Start    = start_q;
    assign bus.Div_Dividend = dvd_q;
    assign bus.Div_Divisor  = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter: behavioural requesters, divider and a
// transaction-level reference model that checks every cycle at the falling edge.
module tb_div_arbiter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          delay;
        int          hold;
        int          gap;
    } job_t;

    logic clk;
    logic rst_n;

    div_arbiter_if #(.WIDTH(WIDTH)) bus ();

    div_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          cyc       = 0;
    job_t        jq[2][$];
    logic        req_lvl[2];
    logic        prev_req[2];
    int          idle_cnt[2];
    logic [15:0] lastq[2];
    logic        laste[2];
    bit          outstanding = 0;
    bit          start_seen  = 0;
    bit          prev_idle   = 1;
    int          served      = 0;
    int          last_served = 1;
    job_t        cur;
    int          exp_valid_at = -1;
    logic [15:0] exp_q;
    logic        exp_e;
    int          grant_log[$];
    bit          sched = 0;
    int          done_at, drop_at, epoch = 0, sched_epoch = 0;
    logic [15:0] sched_q;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [15:0] a, input logic [15:0] b,
                                 input int delay, input int hold, input int gap);
        job_t j;
        j.a = a; j.b = b; j.delay = delay; j.hold = hold; j.gap = gap;
        jq[r].push_back(j);
    endtask

    task automatic driveReq(input int r, input logic lvl, input logic [15:0] a, input logic [15:0] b);
        if (r == 0) begin
            bus.Req0 = lvl; bus.Dividend0 = a; bus.Divisor0 = b;
        end else begin
            bus.Req1 = lvl; bus.Dividend1 = a; bus.Divisor1 = b;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctl"}, {24'd0, bus.Grant0, bus.Grant1, bus.Valid0, bus.Valid1,
                                    bus.Error0, bus.Error1, bus.Busy, bus.Div_Start}, 32'd0);
        checkOutput({tag, "_quot"}, {bus.Quotient1, bus.Quotient0}, 32'd0);
        checkOutput({tag, "_oper"}, {bus.Div_Divisor, bus.Div_Dividend}, 32'd0);
    endtask

    function automatic logic [15:0] refDiv(input logic [15:0] a, input logic [15:0] b);
        int ai, bi, qi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        qi = ai / bi;
        return qi[15:0];
    endfunction

    // Reference model, requesters and divider all live in one process so their
    // bookkeeping never races; every observation happens on the falling edge.
    initial begin : monitor
        int who, w;
        bit exp_grant;
        for (int r = 0; r < 2; r++) begin
            req_lvl[r] = 0; prev_req[r] = 0; idle_cnt[r] = 0; lastq[r] = '0; laste[r] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (sched && cyc == done_at) begin
                bus.Div_Done = 1'b1;
                bus.Div_Quotient = sched_q;
                if (sched_epoch == epoch && outstanding) begin
                    exp_valid_at = cyc + 2; exp_q = sched_q; exp_e = 1'b0;
                end
            end
            if (sched && cyc == drop_at) begin
                bus.Div_Done = 1'b0;
                bus.Div_Quotient = 16'($urandom);
                sched = 0;
            end
            if (!rst_n) begin
                checkResetOutputs("in_reset");
                outstanding = 0; prev_idle = 1; last_served = 1; exp_valid_at = -1; epoch++;
                for (int r = 0; r < 2; r++) begin
                    jq[r].delete(); driveReq(r, 1'b0, '0, '0);
                    req_lvl[r] = 0; prev_req[r] = 0; idle_cnt[r] = 0; lastq[r] = '0; laste[r] = 0;
                end
            end else begin
                exp_grant = prev_idle && (prev_req[0] || prev_req[1]);
                checkOutput("grant_when", {31'd0, bus.Grant0 | bus.Grant1}, {31'd0, exp_grant});
                if (bus.Grant0 && bus.Grant1) checkOutput("grant_both", 32'd1, 32'd0);
                if (bus.Grant0 || bus.Grant1) begin
                    who = bus.Grant1 ? 1 : 0;
                    if (prev_req[0] && prev_req[1]) w = (last_served == 0) ? 1 : 0;
                    else w = prev_req[1] ? 1 : 0;
                    checkOutput("grant_who", who, w);
                    if (jq[who].size() > 0) cur = jq[who].pop_front();
                    else begin cur.a = '0; cur.b = '0; cur.delay = 0; cur.hold = 1; cur.gap = 0; end
                    req_lvl[who] = 0; idle_cnt[who] = 0;
                    driveReq(who, 1'b0, 16'($urandom), 16'($urandom));
                    last_served = who; served = who; outstanding = 1; start_seen = 0; prev_idle = 0;
                    grant_log.push_back(who);
                    if (cur.b == 16'd0) begin
                        exp_valid_at = cyc + 1; exp_q = '0; exp_e = 1'b1;
                    end else begin
                        exp_valid_at = -1;
                    end
                end
                if (bus.Div_Start) begin
                    checkOutput("start_ok", {31'd0, outstanding && !start_seen && cur.b != 16'd0}, 32'd1);
                    if (outstanding && !start_seen && cur.b != 16'd0) begin
                        start_seen = 1;
                        if (cur.delay == 0) begin
                            exp_valid_at = cyc + TIMEOUT + 2; exp_q = '0; exp_e = 1'b1;
                        end else begin
                            sched = 1; sched_epoch = epoch; sched_q = refDiv(cur.a, cur.b);
                            done_at = cyc + cur.delay; drop_at = done_at + cur.hold;
                        end
                    end
                end
                if (outstanding) begin
                    checkOutput("div_operands", {bus.Div_Divisor, bus.Div_Dividend}, {cur.b, cur.a});
                end
                if (bus.Valid0 || bus.Valid1) begin
                    who = bus.Valid1 ? 1 : 0;
                    checkOutput("valid_ok", {31'd0, outstanding && !(bus.Valid0 && bus.Valid1)}, 32'd1);
                    if (outstanding) begin
                        checkOutput("valid_who", who, served);
                        checkOutput("valid_cycle", cyc, exp_valid_at);
                        if (cur.b != 16'd0) checkOutput("one_start", {31'd0, start_seen}, 32'd1);
                        lastq[served] = exp_q; laste[served] = exp_e;
                        outstanding = 0; prev_idle = 1;
                    end
                end else if (outstanding && exp_valid_at >= 0 && cyc > exp_valid_at) begin
                    checkOutput("valid_late", 32'd0, 32'd1);
                    outstanding = 0; prev_idle = 1;
                end
                checkOutput("quot0", {16'd0, bus.Quotient0}, {16'd0, lastq[0]});
                checkOutput("quot1", {16'd0, bus.Quotient1}, {16'd0, lastq[1]});
                checkOutput("err", {30'd0, bus.Error1, bus.Error0}, {30'd0, laste[1], laste[0]});
                checkOutput("busy", {31'd0, bus.Busy}, {31'd0, outstanding});
                for (int r = 0; r < 2; r++) begin
                    if (!req_lvl[r] && jq[r].size() > 0) begin
                        if (idle_cnt[r] >= jq[r][0].gap) begin
                            driveReq(r, 1'b1, jq[r][0].a, jq[r][0].b);
                            req_lvl[r] = 1;
                        end else begin
                            idle_cnt[r]++;
                        end
                    end
                    prev_req[r] = req_lvl[r];
                end
            end
        end
    end

    task automatic waitDrain(input int budget, input string tag);
        int n;
        n = 0;
        while (!(jq[0].size() == 0 && jq[1].size() == 0 && !outstanding &&
                 !req_lvl[0] && !req_lvl[1] && !sched) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) checkOutput({tag, "_drain_timeout"}, 32'd1, 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin : main
        int n;
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        bus.Req0 = 0; bus.Req1 = 0;
        bus.Dividend0 = '0; bus.Dividend1 = '0; bus.Divisor0 = '0; bus.Divisor1 = '0;
        bus.Div_Done = 0; bus.Div_Quotient = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(0, 16'd100, 16'd3, 17, 2, 0);
        waitDrain(200, "single");
        checkOutput("single_q0", {16'd0, bus.Quotient0}, 32'd33);
        checkOutput("single_e0", {31'd0, bus.Error0}, 32'd0);

        #2 rst_n = 1'b0;
        #1 checkResetOutputs("async_reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        grant_log.delete();
        @(posedge clk);
        applyStimulus(0, 16'd255, 16'd10, 5, 1, 0);
        applyStimulus(1, 16'hFF9C, 16'd3, 8, 1, 0);
        waitDrain(200, "tie");
        checkOutput("tie_q0", {16'd0, bus.Quotient0}, 32'd25);
        checkOutput("tie_q1", {16'd0, bus.Quotient1}, 32'h0000FFDF);
        checkOutput("tie_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        grant_log.delete();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 16'($urandom), 16'($urandom_range(1, 500)), $urandom_range(1, 10), 1, 0);
            applyStimulus(1, 16'($urandom), 16'($urandom_range(1, 500)), $urandom_range(1, 10), 1, 0);
        end
        waitDrain(400, "rr");
        checkOutput("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) checkOutput("rr_order", grant_log[i], i % 2);

        applyStimulus(1, 16'd1234, 16'd0, 1, 1, 0);
        waitDrain(50, "divzero");
        checkOutput("divzero_q1", {16'd0, bus.Quotient1}, 32'd0);
        checkOutput("divzero_e1", {31'd0, bus.Error1}, 32'd1);

        applyStimulus(0, 16'd500, 16'd7, 0, 1, 0);
        waitDrain(200, "timeout");
        checkOutput("timeout_q0", {16'd0, bus.Quotient0}, 32'd0);
        checkOutput("timeout_e0", {31'd0, bus.Error0}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 15);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n < 2) rb = 16'd0;
            else if (n == 2) begin ra = 16'h8000; rb = 16'hFFFF; end
            else if (rb == 16'd0) rb = 16'd1;
            applyStimulus($urandom_range(0, 1), ra, rb,
                          ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 20),
                          $urandom_range(1, 3), $urandom_range(0, 5));
        end
        waitDrain(6000, "random");

        applyStimulus(0, 16'd77, 16'd7, 30, 2, 0);
        n = 0;
        while (!(outstanding && start_seen) && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50) checkOutput("midreset_start_timeout", 32'd1, 32'd0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midreset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1 checkOutput("midreset_idle", {31'd0, bus.Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/quotient width, two's-complement signed.
REQ-002 SHALL have parameter TIMEOUT, default 64: max cycles in WAIT before forced error completion.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports Req0/Req1  input  1  per-requester request level, held with operands until Grant.
REQ-006 SHALL have ports Dividend0/Dividend1, Divisor0/Divisor1  input  WIDTH  per-requester operands.
REQ-007 SHALL have ports Grant0/Grant1  output  1  one-cycle pulse: operands accepted.
REQ-008 SHALL have ports Valid0/Valid1  output  1  one-cycle pulse: result ready.
REQ-009 SHALL have ports Quotient0/Quotient1  output  WIDTH  result, held until that requester's next Valid.
REQ-010 SHALL have ports Error0/Error1  output  1  qualifies Valid: divide-by-zero or timeout; held with Quotient.
REQ-011 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have ports Div_Start  output  1, Div_Dividend/Div_Divisor  output  WIDTH: drive the shared divider.
REQ-013 SHALL have ports Div_Quotient  input  WIDTH, Div_Done  input  1: divider result and completion level.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-015 IDLE SHALL sample Req0/Req1 each edge; no request -> stay IDLE.
REQ-016 Single request SHALL be granted; both requests SHALL grant the requester not served last (round-robin bit Last).
REQ-017 On grant edge: latch that requester's operands into Div_Dividend/Div_Divisor, pulse GrantN for the following cycle, update Last.
REQ-018 Granted divisor nonzero -> ISSUE with Div_Start=1 for exactly the ISSUE cycle; next edge -> WAIT.
REQ-019 Granted divisor zero -> go directly to RESP, no Div_Start, result Quotient=0, Error=1.
REQ-020 Div_Done SHALL be edge-detected via register Done_d (updated every cycle); completion = Div_Done & ~Done_d while in WAIT.
REQ-021 On completion edge: capture Div_Quotient into the served QuotientN, ErrorN=0, -> RESP.
REQ-022 WAIT SHALL count cycles from 0; at count TIMEOUT-1 without completion -> RESP with QuotientN=0, ErrorN=1; counter cleared on WAIT entry.
REQ-023 RESP SHALL pulse ValidN for one cycle for the served requester only, then -> IDLE.
REQ-024 Latency (nonzero divisor): Grant 1 cycle after Req sampled; Div_Start next cycle; Valid 1 cycle after Done rising edge seen.
REQ-025 Divide-by-zero latency: Grant cycle followed immediately by Valid cycle.
REQ-026 Req sampled only in IDLE; a Req still high when IDLE is re-entered SHALL count as a new request.
REQ-027 Div_Done edges outside WAIT SHALL be ignored.
REQ-028 Quotient SHALL be passed through unmodified (no saturation; divider overflow result forwarded as-is).
REQ-029 Inputs changing during ISSUE/WAIT/RESP SHALL not affect latched Div_Dividend/Div_Divisor.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE and all outputs 0 (Grant, Valid, Quotient, Error, Busy, Div_Start, Div_Dividend, Div_Divisor), Done_d=0, counter=0.
REQ-031 Reset SHALL set Last=1 so requester 0 wins the first tie.
REQ-032 Reset mid-operation SHALL abandon the operation; no Valid issued for it after release.

Verification
REQ-033 Req0 only, 100/3, model Done after 17 cycles with 33 -> Grant0 one cycle, one Div_Start with Div_Dividend=100/Div_Divisor=3, Valid0 with Quotient0=33, Error0=0.
REQ-034 After reset, Req0 (255/10) and Req1 (-100/3) same cycle -> requester 0 served first: Quotient0=25; then Quotient1=16'hFFDF (-33).
REQ-035 Both Req held high for 4 operations -> grant order 0,1,0,1; exactly one Valid per Grant.
REQ-036 Req1 with Divisor1=0 -> no Div_Start; Grant1 then Valid1 next cycle, Quotient1=0, Error1=1.
REQ-037 Divider model never raises Done -> Valid after 64 WAIT cycles, Quotient=0, Error=1; Busy low next cycle.
REQ-038 Reset asserted during WAIT, later Done edge -> outputs 0 immediately, no Valid, FSM stays IDLE.
